// File: rtl/fpu_flag_pkg.sv
// Shared types for the FP exception-flag path: flag vector, bit positions, CSR op encoding.
package fpu_flag_pkg;

  typedef logic [4:0] fflags_t;

  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // Applies a CSR write/set/clear on top of the current flag value.
  function automatic fflags_t csr_apply(input fflags_t cur, input csr_op_e op,
                                        input fflags_t wdata);
    fflags_t res;
    res = cur;
    case (op)
      CSR_WRITE: res = wdata;
      CSR_SET:   res = cur | wdata;
      CSR_CLEAR: res = cur & ~wdata;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_fifo.sv
// Pointer-based FIFO of flag vectors with synchronous flush, occupancy count, full/empty.
module flag_fifo
  import fpu_flag_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  fflags_t                      wr_data,
  input  logic                         pop,
  input  logic                         flush,
  output fflags_t                      rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fflags_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fma_fflags_commit.sv
// Holds per-op exception flags until commit/flush and maintains the sticky fflags CSR.
// Optional macro FFLAGS_BYPASS_EN: an empty-queue commit paired with a push merges directly.
module fma_fflags_commit
  import fpu_flag_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_invalid,
  input  logic                         in_divzero,
  input  logic                         in_overflow,
  input  logic                         in_underflow,
  input  logic                         in_inexact,
  input  logic                         commit,
  input  logic                         flush,
  input  logic [1:0]                   csr_op,
  input  logic [4:0]                   csr_wdata,
  output logic [4:0]                   fflags,
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt,
  output logic                         commit_err
);

  fflags_t in_flags;
  fflags_t head_flags;
  fflags_t commit_flags;
  fflags_t fflags_d;
  logic    fifo_full;
  logic    fifo_empty;
  logic    push_req;
  logic    bypass_c;
  logic    fifo_push;
  logic    commit_err_d;

  always_comb begin
    in_flags         = '0;
    in_flags[FLG_NV] = in_invalid;
    in_flags[FLG_DZ] = in_divzero;
    in_flags[FLG_OF] = in_overflow;
    in_flags[FLG_UF] = in_underflow;
    in_flags[FLG_NX] = in_inexact;
  end

  assign in_ready = !fifo_full;
  assign push_req = in_valid && in_ready;

`ifdef FFLAGS_BYPASS_EN
  assign bypass_c = commit && fifo_empty && push_req && !flush;
`else
  assign bypass_c = 1'b0;
`endif

  // A bypassed op retires immediately, so it must not also occupy a queue slot.
  assign fifo_push = push_req && !bypass_c;

  flag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data (in_flags),
    .pop     (commit),
    .flush   (flush),
    .rd_data (head_flags),
    .count   (pending_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Commit merges first, then the CSR op sees the merged value.
  always_comb begin
    commit_flags = '0;
    commit_err_d = 1'b0;
    if (commit && !fifo_empty) begin
      commit_flags = head_flags;
    end else if (bypass_c) begin
      commit_flags = in_flags;
    end else if (commit) begin
      commit_err_d = 1'b1;
    end
    fflags_d = csr_apply(fflags | commit_flags, csr_op_e'(csr_op), csr_wdata);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fflags     <= '0;
      commit_err <= 1'b0;
    end else begin
      fflags     <= fflags_d;
      commit_err <= commit_err_d;
    end
  end

endmodule

// File: tb/tb_fma_fflags_commit.sv
// Scoreboard bench for fma_fflags_commit: pending-flag queue model plus sticky fflags model.
module tb_fma_fflags_commit;

  localparam int unsigned DEPTH = 4;
`ifdef FFLAGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready;
  logic       in_invalid, in_divzero, in_overflow, in_underflow, in_inexact;
  logic       commit, flush;
  logic [1:0] csr_op;
  logic [4:0] csr_wdata;
  logic [4:0] fflags;
  logic [2:0] pending_cnt;
  logic       commit_err;

  logic [4:0] exp_q[$];
  logic [4:0] exp_ff;
  logic       exp_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  fma_fflags_commit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_invalid   (in_invalid),
    .in_divzero   (in_divzero),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_inexact   (in_inexact),
    .commit       (commit),
    .flush        (flush),
    .csr_op       (csr_op),
    .csr_wdata    (csr_wdata),
    .fflags       (fflags),
    .pending_cnt  (pending_cnt),
    .commit_err   (commit_err)
  );

  // Drive one cycle of stimulus and advance the model; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [4:0] f, input logic c, input logic fl,
                      input logic [1:0] op, input logic [4:0] wd);
    logic       push_ok;
    logic [4:0] cf;
    logic [4:0] m;
    @(negedge clk);
    in_valid = v;
    {in_invalid, in_divzero, in_overflow, in_underflow, in_inexact} = f;
    commit = c; flush = fl; csr_op = op; csr_wdata = wd;
    push_ok = v && (exp_q.size() < DEPTH);
    cf = '0;
    exp_err = 1'b0;
    if (c) begin
      if (exp_q.size() > 0) cf = exp_q.pop_front();
      else if (BYPASS && push_ok && !fl) begin cf = f; push_ok = 1'b0; end
      else exp_err = 1'b1;
    end
    if (fl) exp_q.delete();
    else if (push_ok) exp_q.push_back(f);
    m = exp_ff | cf;
    case (op)
      2'b01:   exp_ff = wd;
      2'b10:   exp_ff = m | wd;
      2'b11:   exp_ff = m & ~wd;
      default: exp_ff = m;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'b0, 1'b0, 1'b0, 2'b00, 5'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 0; {in_invalid, in_divzero, in_overflow, in_underflow, in_inexact} = '0;
    commit = 0; flush = 0; csr_op = 2'b00; csr_wdata = '0;
    exp_q.delete(); exp_ff = '0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (fflags !== 5'b0) begin n_bad++; $display("FAIL reset_fflags got=%b exp=%b", fflags, 5'b0); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    n_cmp++; if (commit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", commit_err); end
    // Mid-operation reset drops queued entries immediately.
    step(1'b1, 5'b10000, 1'b0, 1'b0, 2'b00, 5'b0);
    step(1'b1, 5'b00100, 1'b0, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (pending_cnt !== 3'd2) begin n_bad++; $display("FAIL pre_reset_cnt got=%0d exp=2", pending_cnt); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (pending_cnt !== 3'd0) begin n_bad++; $display("FAIL async_reset_cnt got=%0d exp=0", pending_cnt); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 5'b00001, 1'b0, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b0) begin n_bad++; $display("FAIL basic_before got=%b exp=%b", fflags, 5'b0); end
    step(1'b0, 5'b0, 1'b1, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b00001) begin n_bad++; $display("FAIL basic_commit got=%b exp=%b", fflags, 5'b00001); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_bad++; $display("FAIL basic_cnt got=%0d exp=0", pending_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 5'b10000, 1'b0, 1'b0, 2'b00, 5'b0);
    step(1'b1, 5'b00100, 1'b0, 1'b0, 2'b00, 5'b0);
    step(1'b0, 5'b0, 1'b0, 1'b1, 2'b00, 5'b0);
    n_cmp++; if (pending_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_cnt got=%0d exp=0", pending_cnt); end
    step(1'b0, 5'b0, 1'b1, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b0) begin n_bad++; $display("FAIL flush_fflags got=%b exp=%b", fflags, 5'b0); end
    n_cmp++; if (commit_err !== 1'b1) begin n_bad++; $display("FAIL flush_err got=%b exp=1", commit_err); end
    idle();
    n_cmp++; if (commit_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got=%b exp=0", commit_err); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 5'(1 << i), 1'b0, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    n_cmp++; if (pending_cnt !== 3'd4) begin n_bad++; $display("FAIL full_cnt got=%0d exp=4", pending_cnt); end
    step(1'b1, 5'b10000, 1'b0, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (pending_cnt !== 3'd4) begin n_bad++; $display("FAIL full_drop got=%0d exp=4", pending_cnt); end
    // No push-through on a full queue even with a commit.
    step(1'b1, 5'b10000, 1'b1, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (pending_cnt !== 3'd3) begin n_bad++; $display("FAIL full_commit_cnt got=%0d exp=3", pending_cnt); end
    for (int i = 0; i < 3; i++) step(1'b0, 5'b0, 1'b1, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b01111) begin n_bad++; $display("FAIL full_or got=%b exp=%b", fflags, 5'b01111); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
    step(1'b1, 5'b10000, 1'b0, 1'b0, 2'b00, 5'b0);
    step(1'b0, 5'b0, 1'b1, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b11111) begin n_bad++; $display("FAIL wrap_entry got=%b exp=%b", fflags, 5'b11111); end
  endtask

  task automatic test_csr();
    do_reset();
    step(1'b0, 5'b0, 1'b0, 1'b0, 2'b10, 5'b00011);
    n_cmp++; if (fflags !== 5'b00011) begin n_bad++; $display("FAIL csr_set got=%b exp=%b", fflags, 5'b00011); end
    step(1'b1, 5'b00010, 1'b0, 1'b0, 2'b00, 5'b0);
    step(1'b0, 5'b0, 1'b1, 1'b0, 2'b11, 5'b00010);
    n_cmp++; if (fflags !== 5'b00001) begin n_bad++; $display("FAIL csr_clear_commit got=%b exp=%b", fflags, 5'b00001); end
    step(1'b0, 5'b0, 1'b0, 1'b0, 2'b01, 5'b10100);
    n_cmp++; if (fflags !== 5'b10100) begin n_bad++; $display("FAIL csr_write got=%b exp=%b", fflags, 5'b10100); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    step(1'b1, 5'b01000, 1'b0, 1'b0, 2'b00, 5'b0);
    step(1'b1, 5'b00100, 1'b1, 1'b1, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b01000) begin n_bad++; $display("FAIL flush_commit got=%b exp=%b", fflags, 5'b01000); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_push_cnt got=%0d exp=0", pending_cnt); end
    step(1'b0, 5'b0, 1'b1, 1'b0, 2'b00, 5'b0);
    n_cmp++; if (fflags !== 5'b01000) begin n_bad++; $display("FAIL of_lost got=%b exp=%b", fflags, 5'b01000); end
  endtask

  task automatic test_bypass();
    do_reset();
    step(1'b1, 5'b00001, 1'b1, 1'b0, 2'b00, 5'b0);
    if (BYPASS) begin
      n_cmp++; if (fflags !== 5'b00001) begin n_bad++; $display("FAIL bypass_ff got=%b exp=%b", fflags, 5'b00001); end
      n_cmp++; if (commit_err !== 1'b0) begin n_bad++; $display("FAIL bypass_err got=%b exp=0", commit_err); end
      n_cmp++; if (pending_cnt !== 3'd0) begin n_bad++; $display("FAIL bypass_cnt got=%0d exp=0", pending_cnt); end
    end else begin
      n_cmp++; if (fflags !== 5'b0) begin n_bad++; $display("FAIL nobypass_ff got=%b exp=%b", fflags, 5'b0); end
      n_cmp++; if (commit_err !== 1'b1) begin n_bad++; $display("FAIL nobypass_err got=%b exp=1", commit_err); end
      n_cmp++; if (pending_cnt !== 3'd1) begin n_bad++; $display("FAIL nobypass_cnt got=%0d exp=1", pending_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] f;
    logic [1:0] op;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      f  = 5'($urandom);
      op = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      step(1'($urandom_range(0, 3) != 0), f, 1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0), op, 5'($urandom));
      n_cmp++;
      if (fflags !== exp_ff || commit_err !== exp_err || pending_cnt !== 3'(exp_q.size())
          || in_ready !== (exp_q.size() < DEPTH)) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d got ff=%b err=%b cnt=%0d rdy=%b exp ff=%b err=%b cnt=%0d",
                 i, fflags, commit_err, pending_cnt, in_ready, exp_ff, exp_err, exp_q.size());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 0; {in_invalid, in_divzero, in_overflow, in_underflow, in_inexact} = '0;
    commit = 0; flush = 0; csr_op = 2'b00; csr_wdata = '0;
    exp_ff = '0; exp_err = 1'b0;
    test_reset();
    test_basic();
    test_flush();
    test_full();
    test_csr();
    test_flush_commit();
    test_bypass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
